// File: rtl/axi4_lite_rr_arbiter.sv
// N-master to 1-slave AXI4-Lite arbiter with independent round-robin read and
// write paths, one outstanding transaction per path, combinational pass-through.
module axi4_lite_rr_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int STRB_WIDTH  = DATA_WIDTH / 8,
   parameter int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   // master-facing ports, master i occupies slice i of each vector
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_awaddr_i,
   input  logic [NUM_MASTERS-1:0]              m_awvalid_i,
   output logic [NUM_MASTERS-1:0]              m_awready_o,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata_i,
   input  logic [NUM_MASTERS*STRB_WIDTH-1:0]   m_wstrb_i,
   input  logic [NUM_MASTERS-1:0]              m_wvalid_i,
   output logic [NUM_MASTERS-1:0]              m_wready_o,
   output logic [NUM_MASTERS*2-1:0]            m_bresp_o,
   output logic [NUM_MASTERS-1:0]              m_bvalid_o,
   input  logic [NUM_MASTERS-1:0]              m_bready_i,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_araddr_i,
   input  logic [NUM_MASTERS-1:0]              m_arvalid_i,
   output logic [NUM_MASTERS-1:0]              m_arready_o,
   output logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_rdata_o,
   output logic [NUM_MASTERS*2-1:0]            m_rresp_o,
   output logic [NUM_MASTERS-1:0]              m_rvalid_o,
   input  logic [NUM_MASTERS-1:0]              m_rready_i,
   // slave-facing port
   output logic [ADDR_WIDTH-1:0]               s_awaddr_o,
   output logic                                s_awvalid_o,
   input  logic                                s_awready_i,
   output logic [DATA_WIDTH-1:0]               s_wdata_o,
   output logic [STRB_WIDTH-1:0]               s_wstrb_o,
   output logic                                s_wvalid_o,
   input  logic                                s_wready_i,
   input  logic [1:0]                          s_bresp_i,
   input  logic                                s_bvalid_i,
   output logic                                s_bready_o,
   output logic [ADDR_WIDTH-1:0]               s_araddr_o,
   output logic                                s_arvalid_o,
   input  logic                                s_arready_i,
   input  logic [DATA_WIDTH-1:0]               s_rdata_i,
   input  logic [1:0]                          s_rresp_i,
   input  logic                                s_rvalid_i,
   output logic                                s_rready_o,
   // status
   output logic [NUM_MASTERS-1:0]              rd_grant_o,
   output logic [NUM_MASTERS-1:0]              wr_grant_o,
   output logic                                rd_busy_o,
   output logic                                wr_busy_o
);

   localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2;
   localparam logic [1:0] W_IDLE = 2'd0, W_REQ  = 2'd1, W_RESP = 2'd2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

   logic [1:0]       rd_state_q, rd_state_d;
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]       wr_state_q, wr_state_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d, wr_ptr_q, wr_ptr_d;
   logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic             ar_fire_s, r_fire_s, aw_fire_s, w_fire_s, b_fire_s;
   logic [NUM_MASTERS-1:0] wr_req_s;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return (idx == LAST_IDX) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
   endfunction

   // First requester at or after ptr, scanning modulo NUM_MASTERS
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                input logic [IDX_W-1:0]       ptr);
      logic [IDX_W-1:0] cand;
      logic [IDX_W-1:0] pick;
      logic             found;
      cand  = ptr;
      pick  = ptr;
      found = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (!found && req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end else begin
            found = found;
         end
         cand = next_idx(cand);
      end
      return pick;
   endfunction

   assign ar_fire_s = s_arvalid_o & s_arready_i;
   assign r_fire_s  = s_rvalid_i  & s_rready_o;
   assign aw_fire_s = s_awvalid_o & s_awready_i;
   assign w_fire_s  = s_wvalid_o  & s_wready_i;
   assign b_fire_s  = s_bvalid_i  & s_bready_o;
   assign wr_req_s  = m_awvalid_i | m_wvalid_i;

   // Read path state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state_q <= R_IDLE;
         rd_idx_q   <= {IDX_W{1'b0}};
         rd_ptr_q   <= {IDX_W{1'b0}};
      end else begin
         rd_state_q <= rd_state_d;
         rd_idx_q   <= rd_idx_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Read path next-state logic
   always_comb begin
      rd_state_d = rd_state_q;
      rd_idx_d   = rd_idx_q;
      rd_ptr_d   = rd_ptr_q;
      case (rd_state_q)
         R_IDLE: begin
            if (|m_arvalid_i) begin
               rd_idx_d   = rr_pick(m_arvalid_i, rd_ptr_q);
               rd_state_d = R_ADDR;
            end else begin
               rd_state_d = R_IDLE;
            end
         end
         R_ADDR: begin
            if (ar_fire_s) begin
               rd_state_d = R_DATA;
            end else begin
               rd_state_d = R_ADDR;
            end
         end
         R_DATA: begin
            if (r_fire_s) begin
               rd_state_d = R_IDLE;
               rd_ptr_d   = next_idx(rd_idx_q);
            end else begin
               rd_state_d = R_DATA;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   // Read path routing between granted master and slave
   always_comb begin
      s_araddr_o  = {ADDR_WIDTH{1'b0}};
      s_arvalid_o = 1'b0;
      s_rready_o  = 1'b0;
      m_arready_o = {NUM_MASTERS{1'b0}};
      m_rvalid_o  = {NUM_MASTERS{1'b0}};
      m_rdata_o   = {(NUM_MASTERS*DATA_WIDTH){1'b0}};
      m_rresp_o   = {(NUM_MASTERS*2){1'b0}};
      rd_grant_o  = {NUM_MASTERS{1'b0}};
      rd_busy_o   = 1'b0;
      case (rd_state_q)
         R_IDLE: rd_busy_o = 1'b0;
         R_ADDR: begin
            rd_busy_o             = 1'b1;
            rd_grant_o[rd_idx_q]  = 1'b1;
            s_araddr_o            = m_araddr_i[rd_idx_q*ADDR_WIDTH +: ADDR_WIDTH];
            s_arvalid_o           = m_arvalid_i[rd_idx_q];
            m_arready_o[rd_idx_q] = s_arready_i;
         end
         R_DATA: begin
            rd_busy_o                                     = 1'b1;
            rd_grant_o[rd_idx_q]                          = 1'b1;
            m_rdata_o[rd_idx_q*DATA_WIDTH +: DATA_WIDTH]  = s_rdata_i;
            m_rresp_o[rd_idx_q*2 +: 2]                    = s_rresp_i;
            m_rvalid_o[rd_idx_q]                          = s_rvalid_i;
            s_rready_o                                    = m_rready_i[rd_idx_q];
         end
         default: rd_busy_o = 1'b0;
      endcase
   end

   // Write path state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state_q <= W_IDLE;
         wr_idx_q   <= {IDX_W{1'b0}};
         wr_ptr_q   <= {IDX_W{1'b0}};
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         wr_idx_q   <= wr_idx_d;
         wr_ptr_q   <= wr_ptr_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
      end
   end

   // Write path next-state logic; AW and W may complete in either order
   always_comb begin
      wr_state_d = wr_state_q;
      wr_idx_d   = wr_idx_q;
      wr_ptr_d   = wr_ptr_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      case (wr_state_q)
         W_IDLE: begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (|wr_req_s) begin
               wr_idx_d   = rr_pick(wr_req_s, wr_ptr_q);
               wr_state_d = W_REQ;
            end else begin
               wr_state_d = W_IDLE;
            end
         end
         W_REQ: begin
            aw_done_d = aw_done_q | aw_fire_s;
            w_done_d  = w_done_q  | w_fire_s;
            if (aw_done_d && w_done_d) begin
               wr_state_d = W_RESP;
            end else begin
               wr_state_d = W_REQ;
            end
         end
         W_RESP: begin
            if (b_fire_s) begin
               wr_state_d = W_IDLE;
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
               wr_ptr_d   = next_idx(wr_idx_q);
            end else begin
               wr_state_d = W_RESP;
            end
         end
         default: begin
            wr_state_d = W_IDLE;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
         end
      endcase
   end

   // Write path routing; a completed channel is masked on both sides
   always_comb begin
      s_awaddr_o  = {ADDR_WIDTH{1'b0}};
      s_awvalid_o = 1'b0;
      s_wdata_o   = {DATA_WIDTH{1'b0}};
      s_wstrb_o   = {STRB_WIDTH{1'b0}};
      s_wvalid_o  = 1'b0;
      s_bready_o  = 1'b0;
      m_awready_o = {NUM_MASTERS{1'b0}};
      m_wready_o  = {NUM_MASTERS{1'b0}};
      m_bvalid_o  = {NUM_MASTERS{1'b0}};
      m_bresp_o   = {(NUM_MASTERS*2){1'b0}};
      wr_grant_o  = {NUM_MASTERS{1'b0}};
      wr_busy_o   = 1'b0;
      case (wr_state_q)
         W_IDLE: wr_busy_o = 1'b0;
         W_REQ: begin
            wr_busy_o             = 1'b1;
            wr_grant_o[wr_idx_q]  = 1'b1;
            s_awaddr_o            = m_awaddr_i[wr_idx_q*ADDR_WIDTH +: ADDR_WIDTH];
            s_awvalid_o           = m_awvalid_i[wr_idx_q] & ~aw_done_q;
            m_awready_o[wr_idx_q] = s_awready_i & ~aw_done_q;
            s_wdata_o             = m_wdata_i[wr_idx_q*DATA_WIDTH +: DATA_WIDTH];
            s_wstrb_o             = m_wstrb_i[wr_idx_q*STRB_WIDTH +: STRB_WIDTH];
            s_wvalid_o            = m_wvalid_i[wr_idx_q] & ~w_done_q;
            m_wready_o[wr_idx_q]  = s_wready_i & ~w_done_q;
         end
         W_RESP: begin
            wr_busy_o                  = 1'b1;
            wr_grant_o[wr_idx_q]       = 1'b1;
            m_bresp_o[wr_idx_q*2 +: 2] = s_bresp_i;
            m_bvalid_o[wr_idx_q]       = s_bvalid_i;
            s_bready_o                 = m_bready_i[wr_idx_q];
         end
         default: wr_busy_o = 1'b0;
      endcase
   end

endmodule

// File: doc/axi4_lite_rr_arbiter.md
Name: axi4_lite_rr_arbiter

Overview:
- Parametrised N-master to 1-slave AXI4-Lite arbiter; lets several bus masters (IFU, LSU, debug) share one memory/peripheral slave.
- Read and write paths are arbitrated independently, each round-robin.
- Each path allows at most one outstanding transaction.
- Sits between the core's memory-access units and the SRAM/UART slave; channel count and bus widths are parameters.

Parameters:
NUM_MASTERS, 2, number of upstream masters (>=1)
ADDR_WIDTH, 32, address width on all ports
DATA_WIDTH, 32, data width; STRB_WIDTH = DATA_WIDTH/8
IDX_W, $clog2(NUM_MASTERS) (min 1), width of grant index/pointer (derived)

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
m  AXI4_Lite.slave  [NUM_MASTERS]  upstream master-facing interface array (ADDR_WIDTH/DATA_WIDTH as parameters)
s  AXI4_Lite.master  1  downstream slave-facing interface
rd_grant  output  NUM_MASTERS  one-hot owner of the read path; 0 when idle
wr_grant  output  NUM_MASTERS  one-hot owner of the write path; 0 when idle
rd_busy  output  1  read FSM not in R_IDLE
wr_busy  output  1  write FSM not in W_IDLE

Behaviour:
Reset:
- rst_n low asynchronously forces both FSMs to IDLE and both round-robin pointers to 0.
- Grants/busy read 0; all s valids and all m readys/valids read 0.
- A transaction in flight at reset is abandoned; no response is delivered.

Read FSM (R_IDLE -> R_ADDR -> R_DATA -> R_IDLE):
- R_IDLE:
  - Requesters are masters with arvalid=1.
  - Winner is the first requester at or after rd_ptr, searching modulo NUM_MASTERS.
  - Winner index is registered and the FSM enters R_ADDR; arbitration costs 1 cycle.
  - No request: the FSM stays in R_IDLE.
- R_ADDR:
  - s.araddr/arvalid are driven from the granted master; that master's arready = s.arready.
  - On s.ar_fire, go to R_DATA.
- R_DATA:
  - The granted master's rdata/rresp/rvalid = s side; s.rready = that master's rready.
  - On s.r_fire: go to R_IDLE and set rd_ptr = grant+1, wrapping NUM_MASTERS-1 -> 0.
Write FSM (W_IDLE -> W_REQ -> W_RESP -> W_IDLE):
- W_IDLE:
  - Requesters are masters with awvalid=1 OR wvalid=1.
  - Winner is chosen the same way, using wr_ptr.
- W_REQ:
  - AW and W channels of the granted master are forwarded to s.
  - aw_done and w_done flags are set on s.aw_fire and s.w_fire, in either order or both in the same cycle.
  - Once a channel is done, its s valid is forced to 0 and its master ready to 0.
  - When both flags are set, go to W_RESP.
- W_RESP:
  - bresp/bvalid are forwarded to the granted master; s.bready = that master's bready.
  - On s.b_fire: go to W_IDLE, clear both flags, set wr_ptr = grant+1 (wrapping).
Common rules:
- Non-granted masters see ready=0 and valid=0 on every channel; rdata/rresp/bresp read 0.
- When a path is idle, its s valids are 0 and s.rready/s.bready are 0.
- Payloads and rresp/bresp (including SLVERR/DECERR) pass through unmodified, combinationally.
- Added latency is the arbitration cycle only; no payload buffering.
- Read and write paths may serve the same or different masters simultaneously.
- Requests arriving while a path is busy wait; they are not sampled until IDLE.
- NUM_MASTERS=1: grant is always master 0; arbitration cycle still present.
- A master dropping valid before handshake violates AXI; behaviour is undefined and not checked.

Test Plan:
- Single read: master 0 araddr=0x8000_0000, slave returns rdata=0xDEAD_BEEF rresp=0 -> rd_grant=01 one cycle after arvalid; master 0 receives 0xDEAD_BEEF; rd_ptr becomes 1.
- Round-robin fairness, NUM_MASTERS=3, all assert arvalid continuously from reset -> grant order 0,1,2,0,1,2; no master served twice before the others are served.
- Write with W before AW: master 1 wvalid at cycle 2 (wdata=0x1234_5678, wstrb=4'b0011), awvalid at cycle 5 (addr 0x10) -> s sees one write; bresp=0 routed only to master 1; master 0 bvalid stays 0.
- Concurrent read+write: master 0 reads 0x100 while master 1 writes 0x200 -> rd_grant=01 and wr_grant=10 in the same cycle; both complete independently.
- Error passthrough and backpressure: slave returns rresp=2'b10; master holds rready=0 for 3 cycles -> s.rready stays 0, rvalid held, master gets rresp=2'b10, FSM leaves R_DATA only on fire.
- Reset mid-transaction: assert rst_n=0 while in W_RESP -> immediately wr_busy=0, wr_grant=0, bvalid=0 to all masters; after release, the next request is granted to master 0.
